// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. Captures two WIDTH-bit operands and a carry-in, then
//   sums them LSB-first through one full-adder cell over WIDTH cycles. The
//   carry between bit positions lives in a single flop that feeds the cell's
//   carry input and captures its carry output.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous reset, active-high
//   start  in   begin an addition (only looked at while idle)
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while an addition is in flight (SHIFT or DONE)
//   done   out  one-cycle pulse when sum/cout have just been updated
//   sum    out  result of the last completed addition
//   cout   out  carry-out of the last completed addition
// ----------------------------------------------------------------------------

// One-bit full-adder cell shared by every bit position.
module serial_adder_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ra_q, ra_d;
   logic [WIDTH-1:0] rb_q, rb_d;
   logic [WIDTH-1:0] rs_q, rs_d;
   logic             cy_q, cy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             fa_s, fa_c;
   logic [WIDTH-1:0] rs_shift;

   serial_adder_fa u_fa (
      .a_i (ra_q[0]),
      .b_i (rb_q[0]),
      .c_i (cy_q),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
   // A one-bit register has nothing to keep, so it just takes the new bit.
   generate
      if (WIDTH == 1) begin : g_rs_w1
         assign rs_shift = fa_s;
      end else begin : g_rs_wn
         assign rs_shift = {fa_s, rs_q[WIDTH-1:1]};
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      ra_d    = ra_q;
      rb_d    = rb_q;
      rs_d    = rs_q;
      cy_d    = cy_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               ra_d    = a;
               rb_d    = b;
               cy_d    = cin;
               cnt_d   = '0;
               rs_d    = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            ra_d  = ra_q >> 1;
            rb_d  = rb_q >> 1;
            rs_d  = rs_shift;
            cy_d  = fa_c;
            cnt_d = cnt_q + 1'b1;
            // The last shift publishes the result directly from the cell
            // outputs, so sum/cout never show a partially built value.
            if (cnt_q == CNT_LAST) begin
               sum_d   = rs_shift;
               cout_d  = fa_c;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         ra_q    <= '0;
         rb_q    <= '0;
         rs_q    <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ra_q    <= ra_d;
         rb_q    <= rb_d;
         rs_q    <= rs_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // Status comes from the state register only: no input-to-output path.
   assign busy = (state_q != S_IDLE);
   assign done = (state_q == S_DONE);
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//   Two instances (WIDTH=8 and WIDTH=1). Drivers push the expected
//   {cout,sum} = a+b+cin and the accept cycle into a per-instance queue;
//   monitors at the falling edge pop on every done pulse and also check
//   latency, busy length and that the result holds between completions.
// ----------------------------------------------------------------------------
module tb_serial_adder;

   typedef struct {
      logic [8:0] v;
      int         acc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endfunction

   // ---------------- WIDTH=8 instance ----------------
   logic       rst8, start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   exp_t       q8[$];

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   // ---------------- WIDTH=1 instance ----------------
   logic       rst1, start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;
   exp_t       q1[$];

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   // ---------------- monitors ----------------
   int         bc8 = 0;
   logic [8:0] last8 = '0;
   exp_t       e8;
   always @(negedge clk) begin
      if (rst8) begin
         bc8   = 0;
         last8 = '0;
      end else begin
         if (busy8) bc8++;
         else if (bc8 != 0) begin
            chk("busy_len8", bc8, 9);
            bc8 = 0;
         end
         if (done8) begin
            if (q8.size() == 0) begin
               errors++;
               $display("FAIL spurious_done8: done with no outstanding request (cycle %0d)", cyc);
            end else begin
               e8 = q8.pop_front();
               chk("sum8", {23'd0, cout8, sum8}, {23'd0, e8.v});
               chk("latency8", cyc - e8.acc, 8);
               last8 = e8.v;
            end
         end else begin
            chk("hold8", {23'd0, cout8, sum8}, {23'd0, last8});
         end
      end
   end

   int         bc1 = 0;
   logic [1:0] last1 = '0;
   exp_t       e1;
   always @(negedge clk) begin
      if (rst1) begin
         bc1   = 0;
         last1 = '0;
      end else begin
         if (busy1) bc1++;
         else if (bc1 != 0) begin
            chk("busy_len1", bc1, 2);
            bc1 = 0;
         end
         if (done1) begin
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL spurious_done1: done with no outstanding request (cycle %0d)", cyc);
            end else begin
               e1 = q1.pop_front();
               chk("sum1", {30'd0, cout1, sum1}, {23'd0, e1.v});
               chk("latency1", cyc - e1.acc, 1);
               last1 = e1.v[1:0];
            end
         end else begin
            chk("hold1", {30'd0, cout1, sum1}, {30'd0, last1});
         end
      end
   end

   // ---------------- drivers ----------------
   // Inputs change 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle8();
      int t = 0;
      while (busy8 && t < 100) begin
         step();
         t++;
      end
      if (t >= 100) begin
         errors++;
         $display("FAIL idle_timeout8: busy stuck high");
      end
   endtask

   task automatic wait_idle1();
      int t = 0;
      while (busy1 && t < 100) begin
         step();
         t++;
      end
      if (t >= 100) begin
         errors++;
         $display("FAIL idle_timeout1: busy stuck high");
      end
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
      exp_t e;
      wait_idle8();
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      step();
      e.v   = 9'(a) + 9'(b) + 9'(c);
      e.acc = cyc;
      q8.push_back(e);
      start8 = 1'b0;
      // Operands are free to change after the accept.
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
   endtask

   task automatic issue1(input logic a, input logic b, input logic c);
      exp_t e;
      wait_idle1();
      a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
      step();
      e.v   = 9'(a) + 9'(b) + 9'(c);
      e.acc = cyc;
      q1.push_back(e);
      start1 = 1'b0;
      a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      int   t;
      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (3) step();
      // start during reset must be ignored
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
      step();
      rst8 = 1'b0; rst1 = 1'b0; start8 = 1'b0;
      chk("rst_busy8", {31'd0, busy8}, 0);
      chk("rst_done8", {31'd0, done8}, 0);
      chk("rst_sum8", {23'd0, cout8, sum8}, 0);
      chk("rst_busy1", {31'd0, busy1}, 0);
      chk("rst_sum1", {30'd0, cout1, sum1}, 0);

      // directed
      issue8(8'h5A, 8'h33, 1'b0);
      issue8(8'hFF, 8'h01, 1'b0);
      issue8(8'hFF, 8'hFF, 1'b1);
      issue8(8'h00, 8'h00, 1'b0);

      // start held high; operands change two cycles after the accept
      wait_idle8();
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      step();
      e.v = 9'h030; e.acc = cyc; q8.push_back(e);
      step();
      step();
      a8 = 8'hAA; b8 = 8'h55;
      repeat (8) step();
      e.v = 9'(8'hAA) + 9'(8'h55); e.acc = cyc; q8.push_back(e);
      start8 = 1'b0;

      // reset during the fourth SHIFT cycle aborts
      wait_idle8();
      a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
      step();
      start8 = 1'b0;
      repeat (3) step();
      rst8 = 1'b1;
      step();
      rst8 = 1'b0;
      chk("abort_busy8", {31'd0, busy8}, 0);
      chk("abort_done8", {31'd0, done8}, 0);
      chk("abort_sum8", {23'd0, cout8, sum8}, 0);
      repeat (12) step();
      issue8(8'h7F, 8'h01, 1'b0);

      // WIDTH=1 directed
      issue1(1'b1, 1'b1, 1'b1);
      issue1(1'b0, 1'b0, 1'b0);

      // random regression on both widths in parallel
      fork
         for (int i = 0; i < 1000; i++)
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
         for (int j = 0; j < 1000; j++)
            issue1(1'($urandom), 1'($urandom), 1'($urandom));
      join

      t = 0;
      while ((q8.size() != 0 || q1.size() != 0) && t < 100) begin
         step();
         t++;
      end
      if (t >= 100) begin
         errors++;
         $display("FAIL drain: %0d/%0d results never arrived", q8.size(), q1.size());
      end
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
